// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
// Shares one UART transmitter between three byte sources: XON/XOFF flow
// control (absolute priority, may cut in between bytes of a word), 32-bit
// host response words (sent MSB byte first) and debug echo bytes. Response
// and debug are round-robin arbitrated per word / per byte.
//
// Optional build macro: TXSCHED_WATCHDOG_EN
//   When defined, a watchdog counts IDLE cycles spent with work pending while
//   the UART reports busy. On reaching WDT_CYCLES it raises the sticky
//   o_tx_timeout flag, abandons any partially sent word and grants once
//   regardless of i_tx_busy_n. When undefined, o_tx_timeout is tied low and
//   the scheduler waits on the UART indefinitely.
//
// Ports
//   clk100, rst          system clock, asynchronous active-high reset
//   i_fc_req/i_fc_byte   flow-control byte request (level) / byte
//   o_fc_ack             1-cycle pulse, coincides with the fc byte strobe
//   i_resp_valid/word    response word request / data
//   o_resp_ready         1-cycle pulse, word captured
//   i_dbg_valid/byte     debug byte request / data
//   o_dbg_ready          1-cycle pulse, byte captured
//   i_tx_busy_n          UART idle (high = idle)
//   o_tx_wr_n/o_tx_data  active-low write strobe / byte to UART
//   o_sched_busy         not IDLE, or a word is partially sent
//   o_tx_timeout         sticky watchdog flag
//
// State table
//   S_IDLE   | waiting for UART idle and a pending source; selects and loads a byte
//   S_SEND   | drives the one-cycle write strobe and the matching ack/ready pulse
//   S_SETTLE | waits TX_SETTLE cycles before i_tx_busy_n is trusted again

module uart_tx_scheduler #(
  parameter int TX_SETTLE  = 2,
  parameter int WDT_CYCLES = 2000000
) (
  input  logic        clk100,
  input  logic        rst,
  input  logic        i_fc_req,
  input  logic [7:0]  i_fc_byte,
  output logic        o_fc_ack,
  input  logic        i_resp_valid,
  input  logic [31:0] i_resp_word,
  output logic        o_resp_ready,
  input  logic        i_dbg_valid,
  input  logic [7:0]  i_dbg_byte,
  output logic        o_dbg_ready,
  input  logic        i_tx_busy_n,
  output logic        o_tx_wr_n,
  output logic [7:0]  o_tx_data,
  output logic        o_sched_busy,
  output logic        o_tx_timeout
);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_SETTLE} state_t;
  typedef enum logic [1:0] {SRC_FC, SRC_RESP, SRC_DBG, SRC_WORD} src_t;

  state_t      r_state;
  src_t        r_src;
  logic        r_rr_last_dbg;   // 1: debug won the last resp/dbg decision
  logic [31:0] r_word_sr;
  logic [1:0]  r_byte_idx;
  logic        r_word_active;
  logic [3:0]  r_settle_cnt;
  logic        r_tx_wr_n;
  logic [7:0]  r_tx_data;
  logic        r_fc_ack;
  logic        r_resp_ready;
  logic        r_dbg_ready;
  logic        r_sched_busy;

  logic w_pending;
  logic w_tx_idle;
  logic w_grant_resp;

  function automatic logic [7:0] sel_byte(input logic [31:0] word, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

  assign w_pending    = i_fc_req | r_word_active | i_resp_valid | i_dbg_valid;
  // On a tie the response wins unless it won the previous decision.
  assign w_grant_resp = i_resp_valid & (~i_dbg_valid | r_rr_last_dbg);

`ifdef TXSCHED_WATCHDOG_EN
  localparam int WDT_W = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
  logic [WDT_W-1:0] r_wdt_cnt;
  logic             r_wdt_override;
  logic             r_tx_timeout;

  assign w_tx_idle    = i_tx_busy_n | r_wdt_override;
  assign o_tx_timeout = r_tx_timeout;
`else
  logic w_unused_wdt;
  assign w_unused_wdt = (WDT_CYCLES != 0);
  assign w_tx_idle    = i_tx_busy_n;
  assign o_tx_timeout = 1'b0;
`endif

  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_src          <= SRC_FC;
      r_rr_last_dbg  <= 1'b1;
      r_word_sr      <= '0;
      r_byte_idx     <= 2'd0;
      r_word_active  <= 1'b0;
      r_settle_cnt   <= 4'd0;
      r_tx_wr_n      <= 1'b1;
      r_tx_data      <= 8'h00;
      r_fc_ack       <= 1'b0;
      r_resp_ready   <= 1'b0;
      r_dbg_ready    <= 1'b0;
      r_sched_busy   <= 1'b0;
`ifdef TXSCHED_WATCHDOG_EN
      r_wdt_cnt      <= '0;
      r_wdt_override <= 1'b0;
      r_tx_timeout   <= 1'b0;
`endif
    end else begin
      r_tx_wr_n    <= 1'b1;
      r_fc_ack     <= 1'b0;
      r_resp_ready <= 1'b0;
      r_dbg_ready  <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_tx_idle && w_pending) begin
            r_state      <= S_SEND;
            r_sched_busy <= 1'b1;
`ifdef TXSCHED_WATCHDOG_EN
            r_wdt_cnt      <= '0;
            r_wdt_override <= 1'b0;
`endif
            if (i_fc_req) begin
              r_tx_data <= i_fc_byte;
              r_src     <= SRC_FC;
            end else if (r_word_active) begin
              r_tx_data <= sel_byte(r_word_sr, r_byte_idx);
              r_src     <= SRC_WORD;
            end else if (w_grant_resp) begin
              r_word_sr     <= i_resp_word;
              r_word_active <= 1'b1;
              r_byte_idx    <= 2'd0;
              r_tx_data     <= i_resp_word[31:24];
              r_src         <= SRC_RESP;
              r_rr_last_dbg <= 1'b0;
            end else begin
              r_tx_data     <= i_dbg_byte;
              r_src         <= SRC_DBG;
              r_rr_last_dbg <= 1'b1;
            end
          end else begin
            r_sched_busy <= r_word_active;
`ifdef TXSCHED_WATCHDOG_EN
            if (w_pending && !i_tx_busy_n) begin
              if (r_wdt_cnt == WDT_W'(WDT_CYCLES - 1)) begin
                r_tx_timeout   <= 1'b1;
                r_word_active  <= 1'b0;
                r_byte_idx     <= 2'd0;
                r_wdt_override <= 1'b1;
                r_wdt_cnt      <= '0;
                r_sched_busy   <= 1'b0;
              end else begin
                r_wdt_cnt <= r_wdt_cnt + WDT_W'(1);
              end
            end else begin
              r_wdt_cnt <= '0;
            end
`endif
          end
        end

        S_SEND: begin
          r_tx_wr_n    <= 1'b0;
          r_fc_ack     <= (r_src == SRC_FC);
          r_resp_ready <= (r_src == SRC_RESP);
          r_dbg_ready  <= (r_src == SRC_DBG);
          r_sched_busy <= 1'b1;
          if (r_src == SRC_RESP || r_src == SRC_WORD) begin
            if (r_byte_idx == 2'd3) begin
              r_byte_idx    <= 2'd0;
              r_word_active <= 1'b0;
            end else begin
              r_byte_idx <= r_byte_idx + 2'd1;
            end
          end
          r_settle_cnt <= 4'(TX_SETTLE - 1);
          r_state      <= S_SETTLE;
        end

        S_SETTLE: begin
          if (r_settle_cnt == 4'd0) begin
            r_state      <= S_IDLE;
            r_sched_busy <= r_word_active;
          end else begin
            r_settle_cnt <= r_settle_cnt - 4'd1;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_tx_wr_n    = r_tx_wr_n;
  assign o_tx_data    = r_tx_data;
  assign o_fc_ack     = r_fc_ack;
  assign o_resp_ready = r_resp_ready;
  assign o_dbg_ready  = r_dbg_ready;
  assign o_sched_busy = r_sched_busy;

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Shares the single UART transmitter (byte write strobe plus TX_busy_n handshake) among three sources:
  - XON/XOFF flow-control bytes,
  - 32-bit host response words, serialized MSB byte first,
  - debug echo bytes.
- Flow control has absolute priority and may interleave between bytes of a word.
- Response and debug sources are round-robin arbitrated at word/byte granularity.
- Sits between the host UART interface logic and the UART core.

Parameters:
- TX_SETTLE, 2: cycles after a write strobe before tx_busy_n is trusted again (1..15).
- WDT_CYCLES, 2000000: watchdog limit in clk100 cycles (used only with the optional feature).

Ports:
- clk100  in  1  system clock
- rst  in  1  reset
- fc_req  in  1  flow-control byte pending (level)
- fc_byte  in  8  flow-control byte (XON 8'h11 / XOFF 8'h13)
- fc_ack  out  1  1-cycle pulse: fc_byte issued
- resp_valid  in  1  response word available
- resp_word  in  32  response word
- resp_ready  out  1  1-cycle pulse: resp_word captured
- dbg_valid  in  1  debug byte available
- dbg_byte  in  8  debug byte
- dbg_ready  out  1  1-cycle pulse: dbg_byte captured
- tx_busy_n  in  1  UART transmitter idle (high = idle)
- tx_wr_n  out  1  active-low write strobe to UART
- tx_data  out  8  byte to UART
- sched_busy  out  1  high while not in IDLE or a word is partially sent
- tx_timeout  out  1  sticky watchdog flag

Behaviour:
- Reset is asynchronous, active-high on rst; all logic is clocked by clk100.
- Reset values:
  - tx_wr_n=1
  - tx_data=0, fc_ack=0, resp_ready=0, dbg_ready=0, sched_busy=0, tx_timeout=0
  - state=IDLE, byte_idx=0, word_active=0, rr_last=DBG (so response wins the first tie)
- All outputs are registered.
- State machine:
  - IDLE:
    - Requires tx_busy_n=1.
    - Selection order:
      - fc_req=1 -> load fc_byte, pulse fc_ack.
      - Else if word_active -> load word_sr byte byte_idx.
      - Else arbitrate resp_valid vs dbg_valid. If both are set, grant the source not equal to rr_last, then update rr_last.
        - Response grant: capture resp_word into word_sr, pulse resp_ready, set word_active, byte_idx=0, load word_sr[31:24].
        - Debug grant: load dbg_byte, pulse dbg_ready.
    - Any load -> go to SEND.
    - tx_busy_n=0 or nothing pending -> stay in IDLE.
  - SEND:
    - tx_wr_n=0 for exactly one cycle; tx_data holds the loaded byte.
    - Word bytes: byte_idx increments; when byte_idx reaches 3, clear word_active.
    - Next state: SETTLE.
  - SETTLE: count TX_SETTLE cycles, ignoring tx_busy_n, then go to IDLE.
- Latency: request -> tx_wr_n low in 2 cycles when the transmitter is idle.
- Minimum byte spacing is 2+TX_SETTLE cycles plus the UART busy time.
- Byte order: resp_word[31:24], [23:16], [15:8], [7:0]; byte_idx wraps 3->0.
- While word_active, debug is never granted; fc may be inserted between any two word bytes.
- fc_req still high after fc_ack sends the byte again; the requester must drop fc_req on fc_ack.
- resp_valid/dbg_valid dropped before ready: the request is not lost state, simply not granted; no capture.
- Simultaneous fc_req, resp_valid and dbg_valid: fc first, then response, then debug (rr), one item per IDLE visit.
- rst mid-word: word is abandoned, no remaining bytes sent; tx_wr_n returns high immediately.

Optional Feature:
- Macro TXSCHED_WATCHDOG_EN.
- Defined:
  - Counter runs while in IDLE with a pending request and tx_busy_n=0.
  - Reaching WDT_CYCLES sets tx_timeout (sticky until rst) and flushes word_active/byte_idx.
  - The scheduler then treats tx_busy_n as idle for one grant.
- Not defined: no counter, tx_timeout tied to 0, waits indefinitely.

Test Plan:
- Response word 32'hA1B2C3D4, tx_busy_n pulsed low 10 cycles after each strobe -> tx_data sequence A1,B2,C3,D4; one resp_ready pulse; 4 tx_wr_n pulses, each 1 cycle wide.
- fc_req with fc_byte=8'h13 asserted during the second byte of word 32'h01020304 -> order 01,02,13,03,04; fc_ack coincides with the 13 strobe.
- resp_valid and dbg_valid held continuously with dbg_byte=8'h55 -> after reset the grants alternate word(4 bytes),55,word,55; no 55 appears inside a word.
- tx_busy_n held 0 with dbg_valid=1 -> no tx_wr_n strobe and no dbg_ready; release -> strobe 2 cycles later.
- rst asserted after byte 2 of word 32'hDEADBEEF -> no BE/EF bytes; all outputs at reset values in the same cycle.
- TXSCHED_WATCHDOG_EN with WDT_CYCLES=100, tx_busy_n stuck 0, fc_req=1 -> tx_timeout=1 at cycle 100; fc byte issued next; flag stays 1.
